ysyx_25060170_rf: RTL

YSYX_25060170_RF -- requirements
Module: ysyx_25060170_RF

---
 rtl/ysyx_25060170_rf.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ysyx_25060170_rf.sv
// ysyx_25060170_rf: 32 x 32-bit register file with per-register pending
// (scoreboard) counters for in-flight writebacks.
// Optional write-to-read forwarding is enabled by defining the macro
// YSYX_25060170_RF_BYPASS_EN. The default build, with the macro undefined,
// returns only stored values.
module ysyx_25060170_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ready_o,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  input  logic        issue_en_i,
  input  logic [4:0]  issue_rd_i,
  output logic        issue_stall_o
);

  // Flattened views of every register and counter; entry 0 is tied to zero.
  logic [31:0] data_view [32];
  logic [1:0]  cnt_view  [32];

  logic guard_reg;
  logic ready_reg;
  logic wb_acc;
  logic issue_acc;
  logic wb_hits_rd;

  assign wb_ready_o = ready_reg;
  assign wb_acc     = wb_valid_i && ready_reg;
  assign wb_hits_rd = wb_acc && (wb_addr_i == issue_rd_i);

  // A saturated destination stalls unless a writeback retires one of its
  // pending entries in the same cycle, which frees the slot.
  assign issue_stall_o = issue_en_i && (cnt_view[issue_rd_i] == 2'd3) && !wb_hits_rd;
  assign issue_acc     = issue_en_i && !issue_stall_o && (issue_rd_i != 5'd0);

  // Ready comes up two edges after reset release; guard_reg is the one-cycle guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard_reg <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      guard_reg <= 1'b1;
      ready_reg <= guard_reg;
    end
  end

  assign data_view[0] = 32'd0;
  assign cnt_view[0]  = 2'd0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi = gi + 1) begin : g_reg
      logic [31:0] data_reg;
      logic [1:0]  cnt_reg;
      logic        wr_hit;
      logic        inc_hit;

      assign wr_hit  = wb_acc && (wb_addr_i == 5'(gi));
      assign inc_hit = issue_acc && (issue_rd_i == 5'(gi));

      // Register storage: written on every accepted writeback to this index.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= 32'd0;
        end else if (wr_hit) begin
          data_reg <= wb_data_i;
        end
      end

      // Pending counter: issue increments, writeback decrements (floored at 0),
      // both at once cancel out.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= 2'd0;
        end else begin
          case ({inc_hit, wr_hit})
            2'b10:   cnt_reg <= cnt_reg + 2'd1;
            2'b01:   cnt_reg <= (cnt_reg != 2'd0) ? cnt_reg - 2'd1 : 2'd0;
            default: cnt_reg <= cnt_reg;
          endcase
        end
      end

      assign data_view[gi] = data_reg;
      assign cnt_view[gi]  = cnt_reg;
    end
  endgenerate

`ifdef YSYX_25060170_RF_BYPASS_EN
  logic rs1_fwd;
  logic rs2_fwd;

  assign rs1_fwd = wb_acc && (wb_addr_i != 5'd0) && (wb_addr_i == rs1_addr_i);
  assign rs2_fwd = wb_acc && (wb_addr_i != 5'd0) && (wb_addr_i == rs2_addr_i);

  // Read ports forward same-cycle writeback data; the last pending entry
  // retiring this cycle is no longer reported busy.
  always_comb begin
    rs1_data_o = rs1_fwd ? wb_data_i : data_view[rs1_addr_i];
    rs2_data_o = rs2_fwd ? wb_data_i : data_view[rs2_addr_i];
    rs1_busy_o = (cnt_view[rs1_addr_i] != 2'd0) && !(rs1_fwd && (cnt_view[rs1_addr_i] == 2'd1));
    rs2_busy_o = (cnt_view[rs2_addr_i] != 2'd0) && !(rs2_fwd && (cnt_view[rs2_addr_i] == 2'd1));
  end
`else
  // Read ports return stored state only; writes become visible next cycle.
  always_comb begin
    rs1_data_o = data_view[rs1_addr_i];
    rs2_data_o = data_view[rs2_addr_i];
    rs1_busy_o = (cnt_view[rs1_addr_i] != 2'd0);
    rs2_busy_o = (cnt_view[rs2_addr_i] != 2'd0);
  end
`endif

endmodule
